// File: rtl/pmp_access_ctrl.sv
// Memory-access sequencer in front of the PMP checker: captures a core request, checks alignment
// and PMP permission, then either issues the bus access or raises a trap with a saturating count.
module pmp_access_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_oper_i,
  input  logic [1:0]       req_size_i,
  input  logic [1:0]       req_priv_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
  input  logic             flush_i,
  output logic [31:0]      chk_addr_o,
  output logic [1:0]       chk_oper_o,
  output logic [1:0]       chk_size_o,
  output logic [1:0]       chk_priv_o,
  input  logic [1:0]       permission_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             mem_we_o,
  output logic [1:0]       mem_size_o,
  input  logic             mem_rsp_valid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             exc_valid_o,
  input  logic             exc_ack_i,
  output logic [3:0]       exc_cause_o,
  output logic [31:0]      exc_tval_o,
  output logic [CNT_W-1:0] fault_count_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StCheck, StMemReq, StMemRsp, StFault} state_e;

  state_e           state_q;
  logic [1:0]       oper_q, size_q, priv_q;
  logic [31:0]      addr_q, wdata_q;
  logic             req_ready_q, rsp_valid_q, mem_req_valid_q, exc_valid_q, drop_q;
  logic [31:0]      rsp_rdata_q, exc_tval_q;
  logic [3:0]       exc_cause_q;
  logic [CNT_W-1:0] fault_cnt_q;

  logic             misaligned, fault;
  logic [3:0]       cause_base, fault_cause;
  logic             unused_perm_hi;

  assign unused_perm_hi = permission_i[1];

  always_comb begin
    misaligned = 1'b0;
    cause_base = 4'd0;
    unique case (size_q)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = |addr_q[1:0];
      default: misaligned = 1'b1;
    endcase
    unique case (oper_q)
      2'b00:   cause_base = 4'd0;
      2'b01:   cause_base = 4'd4;
      default: cause_base = 4'd6;
    endcase
    fault       = misaligned | ~permission_i[0];
    // Misaligned codes are even; the matching access-fault code is the next odd value.
    fault_cause = cause_base | {3'b000, ~misaligned};
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q         <= StIdle;
      oper_q          <= 2'b00;
      size_q          <= 2'b00;
      priv_q          <= 2'b00;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= 32'h0;
      mem_req_valid_q <= 1'b0;
      exc_valid_q     <= 1'b0;
      exc_cause_q     <= 4'd0;
      exc_tval_q      <= 32'h0;
      fault_cnt_q     <= '0;
      drop_q          <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && !flush_i) begin
            oper_q      <= req_oper_i;
            size_q      <= req_size_i;
            priv_q      <= req_priv_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            req_ready_q <= 1'b0;
            state_q     <= StCheck;
          end
        end
        StCheck: begin
          if (flush_i) begin
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end else if (fault) begin
            exc_valid_q <= 1'b1;
            exc_cause_q <= fault_cause;
            exc_tval_q  <= addr_q;
            if (fault_cnt_q != '1) fault_cnt_q <= fault_cnt_q + CntOne;
            state_q     <= StFault;
          end else begin
            mem_req_valid_q <= 1'b1;
            state_q         <= StMemReq;
          end
        end
        StMemReq: begin
          // A flush coinciding with the handshake still lets the bus transfer complete.
          if (mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            drop_q          <= flush_i;
            state_q         <= StMemRsp;
          end else if (flush_i) begin
            mem_req_valid_q <= 1'b0;
            req_ready_q     <= 1'b1;
            state_q         <= StIdle;
          end
        end
        StMemRsp: begin
          if (mem_rsp_valid_i) begin
            if (!(drop_q || flush_i)) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= oper_q[1] ? 32'h0 : mem_rdata_i;
            end
            drop_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end else if (flush_i) begin
            drop_q <= 1'b1;
          end
        end
        StFault: begin
          if (exc_ack_i || flush_i) begin
            exc_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o     = req_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign chk_addr_o      = addr_q;
  assign chk_oper_o      = oper_q;
  assign chk_size_o      = size_q;
  assign chk_priv_o      = priv_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_we_o        = oper_q[1];
  assign mem_size_o      = size_q;
  assign exc_valid_o     = exc_valid_q;
  assign exc_cause_o     = exc_cause_q;
  assign exc_tval_o      = exc_tval_q;
  assign fault_count_o   = fault_cnt_q;

endmodule

// File: tb/tb_pmp_access_ctrl.sv
// Scoreboard bench for pmp_access_ctrl: directed cases plus randomized traffic against a
// rule-level reference model, with a reactive bus responder and trap-unit acknowledger.
module tb_pmp_access_ctrl;
  localparam int unsigned CntW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid = 1'b0, req_ready_o;
  logic [1:0]      req_oper = 2'd0, req_size = 2'd0, req_priv = 2'd0;
  logic [31:0]     req_addr = 32'h0, req_wdata = 32'h0;
  logic            rsp_valid_o;
  logic [31:0]     rsp_rdata_o;
  logic            flush = 1'b0;
  logic [31:0]     chk_addr_o;
  logic [1:0]      chk_oper_o, chk_size_o, chk_priv_o;
  logic [1:0]      permission = 2'd0;
  logic            mem_req_valid_o, mem_req_ready = 1'b0;
  logic [31:0]     mem_addr_o, mem_wdata_o;
  logic            mem_we_o;
  logic [1:0]      mem_size_o;
  logic            mem_rsp_valid = 1'b0;
  logic [31:0]     mem_rdata = 32'h0;
  logic            exc_valid_o, exc_ack = 1'b0;
  logic [3:0]      exc_cause_o;
  logic [31:0]     exc_tval_o;
  logic [CntW-1:0] fault_count_o;

  pmp_access_ctrl #(.CNT_W(CntW)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_oper_i(req_oper),
    .req_size_i(req_size), .req_priv_i(req_priv), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .flush_i(flush), .chk_addr_o(chk_addr_o), .chk_oper_o(chk_oper_o),
    .chk_size_o(chk_size_o), .chk_priv_o(chk_priv_o), .permission_i(permission),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_size_o(mem_size_o), .mem_rsp_valid_i(mem_rsp_valid), .mem_rdata_i(mem_rdata),
    .exc_valid_o(exc_valid_o), .exc_ack_i(exc_ack), .exc_cause_o(exc_cause_o),
    .exc_tval_o(exc_tval_o), .fault_count_o(fault_count_o)
  );

  typedef struct {
    bit          is_exc;
    logic [31:0] rdata;
    logic [3:0]  cause;
    logic [31:0] tval;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0, n_err = 0;
  int          model_cnt = 0;
  logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;
  logic [1:0]  cur_oper = 2'd0, cur_size = 2'd0;
  bit          cur_mem_ok = 1'b0;
  int          stall_left = 0, rsp_dly = 0, ack_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got a pulse, expected none", name);
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Rule-level model: access class, alignment by modulo, RISC-V mcause table.
  function automatic exp_t model(input logic [1:0] oper, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [1:0] perm);
    exp_t e;
    int   kind, code, bytes;
    bit   mis;
    kind  = (oper == 2'd0) ? 0 : ((oper == 2'd1) ? 1 : 2);
    bytes = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    mis   = (size == 2'd3) || ((addr % bytes) != 0);
    e.tval = addr;
    e.rdata = 32'h0;
    e.cause = 4'd0;
    e.is_exc = mis || (perm % 2 == 0);
    if (e.is_exc) begin
      code = (kind == 0) ? 0 : ((kind == 1) ? 4 : 6);
      if (!mis) code = code + 1;
      e.cause = 4'(code);
    end else if (kind != 2) begin
      e.rdata = mem_fn(addr);
    end
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response or a new exception.
  initial begin : monitor
    bit   exc_prev;
    exp_t cur, held;
    exc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) unexpected("rsp_valid");
        else begin
          cur = exp_q.pop_front();
          check("rsp_kind", 32'd0, 32'(cur.is_exc));
          if (!cur.is_exc) check("rsp_rdata", rsp_rdata_o, cur.rdata);
        end
      end
      if (exc_valid_o && !exc_prev) begin
        if (exp_q.size() == 0) unexpected("exc_valid");
        else begin
          held = exp_q.pop_front();
          check("exc_kind", 32'd1, 32'(held.is_exc));
          check("exc_cause", 32'(exc_cause_o), 32'(held.cause));
          check("exc_tval", exc_tval_o, held.tval);
        end
      end else if (exc_valid_o) begin
        check("exc_cause_hold", 32'(exc_cause_o), 32'(held.cause));
        check("exc_tval_hold", exc_tval_o, held.tval);
      end
      exc_prev = exc_valid_o;
    end
  end

  // Bus responder: drives just after each edge; checks the request while it is presented.
  initial begin : bus
    bit          rsp_wait, hs_pending, rsp_given;
    int          dly_left;
    logic [31:0] rsp_addr;
    rsp_wait = 0; hs_pending = 0; rsp_given = 0; dly_left = 0; rsp_addr = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) rsp_wait = 0;
      else if (hs_pending) begin rsp_wait = 1; dly_left = rsp_dly; end
      else if (rsp_given) rsp_wait = 0;
      hs_pending = 0;
      rsp_given = 0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata = $urandom;
      if (rsp_wait) begin
        if (dly_left == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rdata = mem_fn(rsp_addr);
          rsp_given = 1;
        end else dly_left--;
      end else if (mem_req_valid_o) begin
        check("mem_req_allowed", 32'd1, 32'(cur_mem_ok));
        check("mem_addr", mem_addr_o, cur_addr);
        check("mem_we", 32'(mem_we_o), 32'(cur_oper[1]));
        check("mem_size", 32'(mem_size_o), 32'(cur_size));
        if (cur_oper[1]) check("mem_wdata", mem_wdata_o, cur_wdata);
        if (stall_left == 0) begin
          mem_req_ready = 1'b1;
          hs_pending = 1;
          rsp_addr = mem_addr_o;
        end else stall_left--;
      end
    end
  end

  // Returns at the negedge right after the accepting edge (DUT in CHECK).
  task automatic issue(input logic [1:0] oper, input logic [1:0] size, input logic [1:0] priv,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] perm, input bit push);
    exp_t e;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready_o), 32'd1);
    e = model(oper, size, addr, perm);
    cur_addr = addr; cur_oper = oper; cur_size = size; cur_wdata = wdata;
    cur_mem_ok = !e.is_exc && push;
    if (push) begin
      exp_q.push_back(e);
      if (e.is_exc && model_cnt < 3) model_cnt++;
    end
    req_valid = 1'b1; req_oper = oper; req_size = size; req_priv = priv;
    req_addr = addr; req_wdata = wdata; permission = perm;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_oper = 2'($urandom); req_size = 2'($urandom);
    check("chk_addr", chk_addr_o, addr);
    check("chk_oper", 32'(chk_oper_o), 32'(oper));
    check("chk_size", 32'(chk_size_o), 32'(size));
    check("chk_priv", 32'(chk_priv_o), 32'(priv));
  endtask

  task automatic finish_txn(output int lat);
    bit done;
    lat = -1;
    done = 0;
    for (int i = 1; i <= 80 && !done; i++) begin
      @(negedge clk);
      exc_ack = 1'b0;
      if (rsp_valid_o && lat < 0) lat = i;
      if (exc_valid_o) begin
        if (ack_left > 0) ack_left--;
        else exc_ack = 1'b1;
      end
      if (req_ready_o && !rsp_valid_o) done = 1;
    end
    exc_ack = 1'b0;
    if (!done) unexpected("txn_timeout");
    check("fault_count", 32'(fault_count_o), 32'(model_cnt));
  endtask

  task automatic wait_for(input bit want_exc, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if ((want_exc && exc_valid_o) || (!want_exc && mem_req_valid_o)) seen = 1;
      else @(negedge clk);
    end
    if (!seen) unexpected(name);
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_exc_valid", 32'(exc_valid_o), 32'd0);
    check("rst_exc_cause", 32'(exc_cause_o), 32'd0);
    check("rst_exc_tval", exc_tval_o, 32'd0);
    check("rst_fault_count", 32'(fault_count_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    model_cnt = 0;
    stall_left = 0;
    rst_n = 1'b1;
  endtask

  initial begin : driver
    int lat;
    bit seen_v, seen_hs;
    exp_t dummy;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // Zero-wait load word.
    stall_left = 0; rsp_dly = 0; ack_left = 0;
    issue(2'b01, 2'b10, 2'b11, 32'h0000_1000, 32'h0, 2'b01, 1);
    finish_txn(lat);
    check("load_latency", 32'(lat), 32'd3);

    // Misaligned store half, exception held 5 cycles before ack.
    ack_left = 5;
    issue(2'b10, 2'b01, 2'b00, 32'h0000_2003, 32'hCAFE_0001, 2'b01, 1);
    finish_txn(lat);

    // Access faults on fetch and store.
    issue(2'b00, 2'b10, 2'b00, 32'h8000_0000, 32'h0, 2'b00, 1);
    finish_txn(lat);
    issue(2'b10, 2'b10, 2'b00, 32'h8000_0000, 32'h5555_AAAA, 2'b00, 1);
    finish_txn(lat);

    // Stalled load, then flush while awaiting the response.
    stall_left = 4; rsp_dly = 3;
    issue(2'b01, 2'b10, 2'b01, 32'h0000_0040, 32'h0, 2'b01, 0);
    cur_mem_ok = 1;
    seen_v = 0; seen_hs = 0;
    for (int i = 0; i < 40 && !seen_hs; i++) begin
      @(negedge clk);
      if (mem_req_valid_o) seen_v = 1;
      else if (seen_v) seen_hs = 1;
    end
    if (!seen_hs) unexpected("handshake_timeout");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    finish_txn(lat);
    check("flush_rsp_latency", 32'(lat), 32'hFFFF_FFFF);
    rsp_dly = 0;

    // Flush in CHECK on a request that would fault: nothing raised or counted.
    issue(2'b01, 2'b11, 2'b00, 32'h0000_0101, 32'h0, 2'b00, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_check_ready", 32'(req_ready_o), 32'd1);
    check("flush_check_exc", 32'(exc_valid_o), 32'd0);
    check("flush_check_count", 32'(fault_count_o), 32'(model_cnt));

    // Flush in FAULT: exception withdrawn, count kept.
    issue(2'b01, 2'b01, 2'b00, 32'h0000_0301, 32'h0, 2'b01, 1);
    wait_for(1, "exc_timeout");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fault_exc", 32'(exc_valid_o), 32'd0);
    check("flush_fault_ready", 32'(req_ready_o), 32'd1);
    check("flush_fault_count", 32'(fault_count_o), 32'(model_cnt));

    // Flush in IDLE blocks a simultaneous request.
    @(negedge clk);
    cur_mem_ok = 0;
    req_valid = 1'b1; flush = 1'b1; req_oper = 2'b10; req_size = 2'b11; permission = 2'b00;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", 32'(req_ready_o), 32'd1);
    repeat (2) @(negedge clk);
    check("flush_idle_exc", 32'(exc_valid_o), 32'd0);

    // Saturation: five more faults on a 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      ack_left = k % 3;
      issue(2'(k % 3), 2'b11, 2'b00, 32'h0000_1000 + 32'(k), 32'h0, 2'(k), 1);
      finish_txn(lat);
    end

    // Reset during MEM_REQ.
    stall_left = 10;
    issue(2'b01, 2'b10, 2'b00, 32'h0000_0800, 32'h0, 2'b01, 0);
    cur_mem_ok = 1;
    wait_for(0, "memreq_timeout");
    apply_reset();

    // Reset during FAULT.
    ack_left = 50;
    issue(2'b00, 2'b10, 2'b00, 32'h0000_0902, 32'h0, 2'b01, 1);
    wait_for(1, "exc_timeout2");
    apply_reset();
    ack_left = 0;

    // Normal load after reset.
    issue(2'b01, 2'b00, 2'b00, 32'h0000_0A03, 32'h0, 2'b11, 1);
    finish_txn(lat);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
      stall_left = $urandom_range(3, 0);
      rsp_dly = $urandom_range(3, 0);
      ack_left = $urandom_range(3, 0);
      issue(2'($urandom), 2'($urandom), 2'($urandom), a, $urandom, 2'($urandom), 1);
      finish_txn(lat);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      dummy = exp_q.pop_front();
      check("scoreboard_drained", 32'(exp_q.size() + 1), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
